// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared LD/ST width encodings and LSU state type
package rv32ima_pkg;

  localparam int LDST_WIDTH_W = 3;

  localparam logic [1:0] LDST_B = 2'b00;
  localparam logic [1:0] LDST_H = 2'b01;
  localparam logic [1:0] LDST_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP,
    HOLD
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte strobes, store lane shift and load realign/extend
// Purely combinational; outputs cover a two-word window {hi, lo} starting at the aligned base.
module lsu_lane_align
  import rv32ima_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0]        off,
  input  logic [LDST_WIDTH_W-1:0] width,
  input  logic [XLEN-1:0]         wdata,
  input  logic [XLEN-1:0]         lo,
  input  logic [XLEN-1:0]         hi,
  output logic [NB-1:0]           strb0,
  output logic [NB-1:0]           strb1,
  output logic [XLEN-1:0]         store0,
  output logic [XLEN-1:0]         store1,
  output logic [XLEN-1:0]         load_data
);

  logic [3:0]        bmask;
  logic [XLEN-1:0]   wmask;
  logic [2*NB-1:0]   strb2;
  logic [2*XLEN-1:0] st2;
  logic [XLEN-1:0]   ld_sh;
  logic              sign;

  always_comb begin
    bmask = 4'b1111;
    wmask = '0;
    sign  = 1'b0;
    case (width[1:0])
      LDST_B: begin
        bmask       = 4'b0001;
        wmask[7:0]  = '1;
        sign        = ld_sh[7];
      end
      LDST_H: begin
        bmask       = 4'b0011;
        wmask[15:0] = '1;
        sign        = ld_sh[15];
      end
      default: begin
        bmask       = 4'b1111;
        wmask[31:0] = '1;
        sign        = ld_sh[31];
      end
    endcase
  end

  assign strb2  = {{(2*NB-4){1'b0}}, bmask} << off;
  assign st2    = {{XLEN{1'b0}}, wdata & wmask} << {off, 3'b000};
  assign strb0  = strb2[NB-1:0];
  assign strb1  = strb2[2*NB-1:NB];
  assign store0 = st2[XLEN-1:0];
  assign store1 = st2[2*XLEN-1:XLEN];

  // width[2] selects zero extension for unsigned loads
  assign ld_sh     = XLEN'({hi, lo} >> {off, 3'b000});
  assign load_data = (ld_sh & wmask) | ({XLEN{sign & ~width[2]}} & ~wmask);

endmodule

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - load/store unit request FSM with timeout and optional misaligned split
// MISALIGN_SPLIT_EN: when defined, misaligned H/W accesses become two word accesses; otherwise they trap.
module lsu_split
  import rv32ima_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_ren,
  input  logic                    req_wen,
  input  logic [LDST_WIDTH_W-1:0] req_width,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    done,
  output logic [XLEN-1:0]         load_data,
  output logic                    load_misalign,
  output logic                    store_misalign,
  output logic                    access_fault,
  output logic                    dmem_ren,
  output logic                    dmem_wen,
  output logic [XLEN-1:0]         dmem_addr,
  output logic [XLEN/8-1:0]       dmem_wstrb,
  output logic [XLEN-1:0]         dmem_store,
  input  logic [XLEN-1:0]         dmem_load,
  input  logic                    dhit
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t              state_q, state_d;
  logic [XLEN-1:0]         addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d;
  logic [LDST_WIDTH_W-1:0] width_q, width_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load_q, load_d, lm_q, lm_d, sm_q, sm_d, af_q, af_d;

  logic [XLEN-1:0] base, store0, store1;
  logic [NB-1:0]   strb0, strb1;
  logic            timeout_hit;

  assign base        = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MISALIGN_SPLIT_EN
  logic cross;
  assign cross = |strb1;
`else
  logic misal;
  assign misal = ((req_width[1:0] == LDST_H) && req_addr[0]) ||
                 ((req_width[1:0] == LDST_W) && (req_addr[1:0] != 2'b00));
`endif

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off       (addr_q[OFF_W-1:0]),
    .width     (width_q),
    .wdata     (wdata_q),
    .lo        (lo_q),
    .hi        (hi_q),
    .strb0     (strb0),
    .strb1     (strb1),
    .store0    (store0),
    .store1    (store1),
    .load_data (load_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    width_d = width_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    lm_d    = lm_q;
    sm_d    = sm_q;
    af_d    = af_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (req_ren || req_wen)) begin
          addr_d  = req_addr;
          width_d = req_width;
          wdata_d = req_wdata;
          load_d  = req_ren;
          lo_d    = '0;
          hi_d    = '0;
          cnt_d   = '0;
          lm_d    = 1'b0;
          sm_d    = 1'b0;
          af_d    = 1'b0;
          if (req_ren && req_wen) begin
            af_d    = 1'b1;
            state_d = RESP;
          end else if (req_width[1:0] == 2'b11) begin
            lm_d    = req_ren;
            sm_d    = req_wen;
            state_d = RESP;
          end
`ifndef MISALIGN_SPLIT_EN
          else if (misal) begin
            lm_d    = req_ren;
            sm_d    = req_wen;
            state_d = RESP;
          end
`endif
          else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        if (dhit) begin
          if (load_q) lo_d = dmem_load;
`ifdef MISALIGN_SPLIT_EN
          if (cross) begin
            cnt_d   = '0;
            state_d = ACC1;
          end else
`endif
          state_d = RESP;
        end else if (timeout_hit) begin
          af_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef MISALIGN_SPLIT_EN
      // A fault here leaves the ACC0 bytes of a split store already written
      ACC1: begin
        if (dhit) begin
          if (load_q) hi_d = dmem_load;
          state_d = RESP;
        end else if (timeout_hit) begin
          af_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      RESP:    state_d = HOLD;
      HOLD:    if (!req_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      width_q <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      lm_q    <= 1'b0;
      sm_q    <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      lm_q    <= lm_d;
      sm_q    <= sm_d;
      af_q    <= af_d;
    end
  end

  // Memory strobes decode from the state register only, so dhit never loops back into them
  always_comb begin
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_wstrb = '0;
    dmem_store = '0;
    if (state_q == ACC0) begin
      dmem_ren   = load_q;
      dmem_wen   = ~load_q;
      dmem_addr  = base;
      dmem_wstrb = strb0;
      dmem_store = load_q ? '0 : store0;
    end else if (state_q == ACC1) begin
      dmem_ren   = load_q;
      dmem_wen   = ~load_q;
      dmem_addr  = base + XLEN'(NB);
      dmem_wstrb = strb1;
      dmem_store = load_q ? '0 : store1;
    end
  end

  assign done           = (state_q == RESP);
  assign load_misalign  = done & lm_q;
  assign store_misalign = done & sm_q;
  assign access_fault   = done & af_q;

endmodule

// File: tb/tb_lsu_split.sv
// tb/tb_lsu_split.sv - scoreboard bench for lsu_split (memory accesses and done responses)
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ren = 1'b0, req_wen = 1'b0;
  logic [2:0]  req_width = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        done, load_misalign, store_misalign, access_fault;
  logic [31:0] load_data;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_store;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_load = '0;
  logic        dhit = 1'b0;

  lsu_split #(.XLEN(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ren        (req_ren),
    .req_wen        (req_wen),
    .req_width      (req_width),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .done           (done),
    .load_data      (load_data),
    .load_misalign  (load_misalign),
    .store_misalign (store_misalign),
    .access_fault   (access_fault),
    .dmem_ren       (dmem_ren),
    .dmem_wen       (dmem_wen),
    .dmem_addr      (dmem_addr),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_store     (dmem_store),
    .dmem_load      (dmem_load),
    .dhit           (dhit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] store;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        lm;
    logic        sm;
    logic        af;
    int          lat;
    int          issue;
  } resp_t;

  acc_t        aq[$];
  resp_t       rq[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          hit_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and access monitor
  always @(negedge clk) begin
    acc_t got, e;
    if (!rst && (dmem_ren || dmem_wen) && hit_en) begin
      got = {dmem_ren, dmem_wen, dmem_addr, dmem_wstrb, dmem_store};
      n_checks++;
      if (aq.size() == 0) begin
        n_fail++;
        $display("FAIL access_unexpected: got ren=%0d wen=%0d addr=%h strb=%b store=%h, required no access",
                 got.ren, got.wen, got.addr, got.strb, got.store);
      end else begin
        e = aq.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL access: got ren=%0d wen=%0d addr=%h strb=%b store=%h, required ren=%0d wen=%0d addr=%h strb=%b store=%h",
                   got.ren, got.wen, got.addr, got.strb, got.store, e.ren, e.wen, e.addr, e.strb, e.store);
        end
      end
      dhit      = 1'b1;
      dmem_load = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
    end else begin
      dhit      = 1'b0;
      dmem_load = 32'h0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (done) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got data=%h lm=%0d sm=%0d af=%0d, required no done",
                 load_data, load_misalign, store_misalign, access_fault);
      end else begin
        e = rq.pop_front();
        if ({load_data, load_misalign, store_misalign, access_fault} !== {e.data, e.lm, e.sm, e.af}) begin
          n_fail++;
          $display("FAIL resp: got data=%h lm=%0d sm=%0d af=%0d, required data=%h lm=%0d sm=%0d af=%0d",
                   load_data, load_misalign, store_misalign, access_fault, e.data, e.lm, e.sm, e.af);
        end
        n_checks++;
        if (cyc - e.issue != e.lat) begin
          n_fail++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - e.issue, e.lat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic exp_acc(input logic wen, input logic [31:0] a, input logic [3:0] s, input logic [31:0] st);
    aq.push_back({~wen, wen, a, s, st});
  endtask

  task automatic do_req(input logic ren, input logic wen, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] d, input int hold,
                        input logic [31:0] edata, input logic elm, input logic esm,
                        input logic eaf, input int elat);
    resp_t e;
    bit    got;
    @(negedge clk);
    req_valid = 1'b1;
    req_ren   = ren;
    req_wen   = wen;
    req_width = w;
    req_addr  = a;
    req_wdata = d;
    e.data = edata; e.lm = elm; e.sm = esm; e.af = eaf; e.lat = elat; e.issue = cyc;
    rq.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: got no done within 40 cycles, required done at %h", a);
    end
    repeat (hold) @(negedge clk);
    req_valid = 1'b0;
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h44556677;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        80'({done, load_misalign, store_misalign, access_fault, dmem_ren, dmem_wen,
             dmem_addr, dmem_wstrb, dmem_store, load_data}), 80'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_access", 80'({dmem_ren, dmem_wen, done}), 80'h0);

    // Aligned LW, request held 10 cycles past done: one access, one done
    exp_acc(1'b0, 32'h100, 4'b1111, 32'h0);
    do_req(1, 0, 3'b010, 32'h100, 32'h0, 10, 32'hDEADBEEF, 0, 0, 0, 2);

    mem[32'h100] = 32'h80112233;
    exp_acc(1'b0, 32'h100, 4'b1000, 32'h0);
    do_req(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFF80, 0, 0, 0, 2);
    exp_acc(1'b0, 32'h100, 4'b1000, 32'h0);
    do_req(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h00000080, 0, 0, 0, 2);
    exp_acc(1'b0, 32'h100, 4'b1100, 32'h0);
    do_req(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'hFFFF8011, 0, 0, 0, 2);
    exp_acc(1'b0, 32'h104, 4'b1100, 32'h0);
    do_req(1, 0, 3'b101, 32'h106, 32'h0, 0, 32'h00004455, 0, 0, 0, 2);

    exp_acc(1'b1, 32'h100, 4'b0010, 32'h0000A500);
    do_req(0, 1, 3'b000, 32'h101, 32'hFFFFFFA5, 0, 32'h0, 0, 0, 0, 2);
    exp_acc(1'b1, 32'h200, 4'b1111, 32'h12345678);
    do_req(0, 1, 3'b010, 32'h200, 32'h12345678, 0, 32'h0, 0, 0, 0, 2);

    mem[32'h100] = 32'hDEADBEEF;
`ifdef MISALIGN_SPLIT_EN
    exp_acc(1'b1, 32'h100, 4'b1100, 32'hCCDD0000);
    exp_acc(1'b1, 32'h104, 4'b0011, 32'h0000AABB);
    do_req(0, 1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 32'h0, 0, 0, 0, 3);
    exp_acc(1'b0, 32'h100, 4'b1110, 32'h0);
    exp_acc(1'b0, 32'h104, 4'b0001, 32'h0);
    do_req(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h77DEADBE, 0, 0, 0, 3);
`else
    do_req(0, 1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 32'h0, 0, 1, 0, 1);
    do_req(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1, 0, 0, 1);
`endif

    do_req(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1, 0, 0, 1);
    do_req(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0, 0, 0, 1, 1);

    // Memory never answers: fault 4 cycles after ACC0 entry
    hit_en = 1'b0;
    do_req(1, 0, 3'b010, 32'h300, 32'h0, 3, 32'h0, 0, 0, 1, 5);
    hit_en = 1'b1;
    exp_acc(1'b0, 32'h104, 4'b1111, 32'h0);
    do_req(1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h44556677, 0, 0, 0, 2);

    // Reset while in ACC0
    hit_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_width = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    chk("acc0_ren", 80'({dmem_ren, dmem_addr}), 80'({1'b1, 32'h100}));
    rst = 1'b1;
    #1;
    chk("rst_mid_access", 80'({dmem_ren, dmem_wen, dmem_addr, dmem_wstrb, done}), 80'h0);
    @(negedge clk);
    req_valid = 1'b0; req_ren = 1'b0; rst = 1'b0; hit_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_acc(1'b0, 32'h100, 4'b1111, 32'h0);
    do_req(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 0, 0, 2);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 80'(rq.size()), 80'h0);
    chk("access_queue_empty", 80'(aq.size()), 80'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
Parametrised load/store unit that sits between the datapath's decoded LD/ST command and the data-memory port. It replaces the single-shot "served" flag and the combinational misalign check with a request FSM. Misaligned accesses are either split into two aligned word accesses or trapped, selected by a compile-time macro. Adds byte strobes, a response timeout and sign/zero extension for any XLEN.

Parameters:
XLEN, 32, data/address width; must be a power of two ≥ 32
TIMEOUT, 64, cycles without dhit in an access state before access_fault; 0 disables the timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  LD/ST request; level, held by core for the whole instruction span
req_ren  in  1  load
req_wen  in  1  store
req_width  in  3  [1:0] size (00 B, 01 H, 10 W, 11 illegal); [2] unsigned load
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, LSB-aligned
done  out  1  one-cycle completion pulse
load_data  out  XLEN  extended load result; valid from done, held until next accept
load_misalign  out  1  pulse with done
store_misalign  out  1  pulse with done
access_fault  out  1  pulse with done
dmem_ren  out  1  memory read
dmem_wen  out  1  memory write
dmem_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
dmem_wstrb  out  XLEN/8  byte enables, both reads and writes
dmem_store  out  XLEN  store data shifted into lane position
dmem_load  in  XLEN  read data, valid with dhit
dhit  in  1  memory completes current access this cycle

Behaviour:
- Reset: state IDLE; all outputs 0; load_data 0; counter 0; captured words 0.
- States: IDLE, ACC0, ACC1, RESP, HOLD.
- IDLE: accept when req_valid & (req_ren | req_wen). Latch addr, width, wdata and the op.
  - Both ren and wen set -> RESP with access_fault.
  - Size 11 -> RESP with the matching misalign flag.
  - Misaligned (H: addr[0]; W: addr[1:0] != 0) with split disabled -> RESP with misalign flag; no memory access.
  - Otherwise -> ACC0.
- ACC0: drive dmem_ren/wen, addr = floor(addr), strobes = bytes of the access inside this word, and shifted store data.
  - On dhit: capture dmem_load as lo word.
  - If the access crosses a word boundary -> ACC1; else -> RESP.
- ACC1: addr = floor(addr) + XLEN/8, with strobes and data for the remaining bytes. On dhit: capture hi word -> RESP.
- Timeout:
  - The counter resets on entry to ACC0/ACC1 and increments while dhit = 0.
  - Reaching TIMEOUT -> RESP with access_fault.
  - A split store faulting in ACC1 leaves the ACC0 bytes written; this is not rolled back.
- RESP: done = 1 for exactly one cycle; load_data = {hi,lo} shifted right by addr offset, then sign- or zero-extended per width[2]. -> HOLD.
- HOLD: no memory activity. Return to IDLE when req_valid = 0, so a held request is never replayed. A new request is accepted no earlier than the cycle after req_valid falls.
- Latency, aligned access with dhit on first cycle: accept cycle T, ACC0 at T+1, done at T+2. A split access adds one cycle per extra access.
- dmem_ren/wen are registered from state only, never from dhit, so there is no combinational loop.
- req_valid dropping mid-ACC: the access completes regardless and done is still pulsed.
- rst mid-access: immediate return to IDLE; outputs 0.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: misaligned H/W accesses are split as above; misalign flags assert only for size 11.
- Undefined: ACC1 is not built; misaligned accesses go straight to RESP with load_misalign/store_misalign and never touch memory.

Decomposition:
- Shared package (rv32ima_pkg): LDST_WIDTH_W, the size encodings (LDST_B/H/W), and the lsu_state_t enum.
- One sub-module, lsu_lane_align: purely combinational. Computes strobes, store shift and load realign/extend from offset and width. The FSM module owns the sequencing and the timeout.

Test Plan:
- LW addr 0x100; memory returns 0xDEADBEEF with dhit on the first cycle -> dmem_addr 0x100, wstrb 1111, done 2 cycles after accept, load_data 0xDEADBEEF.
- LB addr 0x103, word 0x80112233, signed -> wstrb 1000, load_data 0xFFFFFF80; same with LBU -> 0x00000080.
- SW addr 0x102, data 0xAABBCCDD, split enabled -> ACC0 addr 0x100 wstrb 1100 store 0xCCDD0000; ACC1 addr 0x104 wstrb 0011 store 0x0000AABB; one done pulse.
- Same SW with split disabled -> no dmem_wen ever; done with store_misalign = 1.
- LW with dhit held 0 and TIMEOUT = 4 -> access_fault with done 4 cycles after ACC0 entry; returns to IDLE after req_valid drops.
- req_valid held 10 cycles after done -> exactly one memory access and one done pulse; rst asserted in ACC0 -> dmem_ren = 0 immediately.
